// File: rtl/i2c_wb_cmd_sequencer_if.sv
// Wishbone bus between the command sequencer (master) and the I2C master core register port (slave).
interface i2c_wb_cmd_sequencer_if;
  logic [2:0] wbm_adr_o;
  logic [7:0] wbm_dat_o;
  logic [7:0] wbm_dat_i;
  logic       wbm_we_o;
  logic       wbm_stb_o;
  logic       wbm_cyc_o;
  logic       wbm_ack_i;

  modport master (
    output wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_stb_o, wbm_cyc_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    input  wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_stb_o, wbm_cyc_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface

// File: rtl/i2c_wb_cmd_sequencer.sv
// Sequences single-byte I2C transactions over the I2C master core's Wishbone register map.
// Optional arbitration-lost abort is enabled with `define I2C_SEQ_ARBLOST_EN.
module i2c_wb_cmd_sequencer #(
  parameter logic [15:0] PRESCALE     = 16'h002D,
  parameter logic [31:0] POLL_TIMEOUT = 32'd200_000,
  parameter logic [7:0]  CTR_INIT     = 8'h80
) (
  input  logic       wb_clk_i,
  input  logic       arst_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic       cmd_rw_i,
  input  logic [6:0] cmd_addr_i,
  input  logic [7:0] cmd_data_i,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_data_o,
  output logic       rsp_nack_o,
  output logic       rsp_timeout_o,
`ifdef I2C_SEQ_ARBLOST_EN
  output logic       rsp_arblost_o,
`endif
  i2c_wb_cmd_sequencer_if.master wb
);

  localparam logic [3:0] INIT_PLO  = 4'd0,  INIT_PHI  = 4'd1,  INIT_CTR = 4'd2,  IDLE     = 4'd3,
                         ADDR_TX   = 4'd4,  ADDR_CMD  = 4'd5,  ADDR_POLL = 4'd6, DATA_TX  = 4'd7,
                         DATA_CMD  = 4'd8,  DATA_POLL = 4'd9,  RD_CMD   = 4'd10, RD_POLL  = 4'd11,
                         RD_DATA   = 4'd12, STOP_CMD  = 4'd13, STOP_POLL = 4'd14, RESP    = 4'd15;

  logic [3:0]  r_state;
  logic        r_cyc, r_we;
  logic [2:0]  r_adr;
  logic [7:0]  r_dat;
  logic        r_rw;
  logic [6:0]  r_addr;
  logic [7:0]  r_wdata;
  logic        r_rsp_valid, r_nack, r_timeout;
  logic [7:0]  r_rsp_data;
  logic [31:0] r_poll_cnt;
`ifdef I2C_SEQ_ARBLOST_EN
  logic        r_arblost;
`endif

  logic        w_acc_we;
  logic [2:0]  w_acc_adr;
  logic [7:0]  w_acc_dat;
  logic        w_poll, w_done, w_al, w_poll_last;

  // Register access implied by each state; polls and RD_DATA are reads.
  always_comb begin
    w_acc_we  = 1'b0;
    w_acc_adr = 3'd4;
    w_acc_dat = 8'h00;
    case (r_state)
      INIT_PLO: begin w_acc_we = 1'b1; w_acc_adr = 3'd0; w_acc_dat = PRESCALE[7:0];  end
      INIT_PHI: begin w_acc_we = 1'b1; w_acc_adr = 3'd1; w_acc_dat = PRESCALE[15:8]; end
      INIT_CTR: begin w_acc_we = 1'b1; w_acc_adr = 3'd2; w_acc_dat = CTR_INIT;       end
      ADDR_TX:  begin w_acc_we = 1'b1; w_acc_adr = 3'd3; w_acc_dat = {r_addr, r_rw}; end
      ADDR_CMD: begin w_acc_we = 1'b1; w_acc_dat = 8'h90; end
      DATA_TX:  begin w_acc_we = 1'b1; w_acc_adr = 3'd3; w_acc_dat = r_wdata;        end
      DATA_CMD: begin w_acc_we = 1'b1; w_acc_dat = 8'h50; end
      RD_CMD:   begin w_acc_we = 1'b1; w_acc_dat = 8'h68; end
      STOP_CMD: begin w_acc_we = 1'b1; w_acc_dat = 8'h40; end
      RD_DATA:  w_acc_adr = 3'd3;
      default:  ;
    endcase
  end

  assign w_poll      = (r_state == ADDR_POLL) || (r_state == DATA_POLL) ||
                       (r_state == RD_POLL)   || (r_state == STOP_POLL);
  assign w_done      = (r_state == STOP_POLL) ? !wb.wbm_dat_i[6] : !wb.wbm_dat_i[1];
  assign w_poll_last = (r_poll_cnt + 32'd1) == POLL_TIMEOUT;
`ifdef I2C_SEQ_ARBLOST_EN
  assign w_al = wb.wbm_dat_i[5];
`else
  assign w_al = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      r_state     <= INIT_PLO;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_adr       <= 3'd0;
      r_dat       <= 8'h00;
      r_rw        <= 1'b0;
      r_addr      <= 7'd0;
      r_wdata     <= 8'h00;
      r_rsp_valid <= 1'b0;
      r_nack      <= 1'b0;
      r_timeout   <= 1'b0;
      r_rsp_data  <= 8'h00;
      r_poll_cnt  <= 32'd0;
`ifdef I2C_SEQ_ARBLOST_EN
      r_arblost   <= 1'b0;
`endif
    end else begin
      r_rsp_valid <= 1'b0;
      if (r_state == IDLE) begin
        if (cmd_valid_i) begin
          r_rw       <= cmd_rw_i;
          r_addr     <= cmd_addr_i;
          r_wdata    <= cmd_data_i;
          r_nack     <= 1'b0;
          r_timeout  <= 1'b0;
          r_rsp_data <= 8'h00;
`ifdef I2C_SEQ_ARBLOST_EN
          r_arblost  <= 1'b0;
`endif
          r_state    <= ADDR_TX;
        end
      end else if (r_state == RESP) begin
        r_state <= IDLE;
      end else if (!r_cyc) begin
        r_cyc <= 1'b1;
        r_we  <= w_acc_we;
        r_adr <= w_acc_adr;
        r_dat <= w_acc_dat;
      end else if (wb.wbm_ack_i) begin
        // Dropping cyc here guarantees an idle cycle before the next access.
        r_cyc      <= 1'b0;
        r_poll_cnt <= w_poll ? r_poll_cnt + 32'd1 : 32'd0;
        case (r_state)
          INIT_PLO: r_state <= INIT_PHI;
          INIT_PHI: r_state <= INIT_CTR;
          INIT_CTR: r_state <= IDLE;
          ADDR_TX:  r_state <= ADDR_CMD;
          ADDR_CMD: r_state <= ADDR_POLL;
          DATA_TX:  r_state <= DATA_CMD;
          DATA_CMD: r_state <= DATA_POLL;
          RD_CMD:   r_state <= RD_POLL;
          STOP_CMD: r_state <= STOP_POLL;
          RD_DATA: begin
            r_rsp_data  <= wb.wbm_dat_i;
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
          end
          default: begin
            if (w_al) begin
`ifdef I2C_SEQ_ARBLOST_EN
              r_arblost <= 1'b1;
`endif
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
            end else if (w_done) begin
              case (r_state)
                ADDR_POLL: begin
                  if (wb.wbm_dat_i[7]) begin
                    r_nack  <= 1'b1;
                    r_state <= STOP_CMD;
                  end else begin
                    r_state <= r_rw ? RD_CMD : DATA_TX;
                  end
                end
                RD_POLL: r_state <= RD_DATA;
                default: begin
                  if (r_state == DATA_POLL) r_nack <= wb.wbm_dat_i[7];
                  r_state     <= RESP;
                  r_rsp_valid <= 1'b1;
                end
              endcase
            end else if (w_poll_last) begin
              // A stuck STOP is not retried; anything else still releases the bus.
              r_timeout <= 1'b1;
              if (r_state == STOP_POLL) begin
                r_state     <= RESP;
                r_rsp_valid <= 1'b1;
              end else begin
                r_state <= STOP_CMD;
              end
            end
          end
        endcase
      end
    end
  end

  assign cmd_ready_o   = (r_state == IDLE);
  assign rsp_valid_o   = r_rsp_valid;
  assign rsp_data_o    = r_rsp_data;
  assign rsp_nack_o    = r_nack;
  assign rsp_timeout_o = r_timeout;
`ifdef I2C_SEQ_ARBLOST_EN
  assign rsp_arblost_o = r_arblost;
`endif
  assign wb.wbm_cyc_o  = r_cyc;
  assign wb.wbm_stb_o  = r_cyc;
  assign wb.wbm_we_o   = r_we;
  assign wb.wbm_adr_o  = r_adr;
  assign wb.wbm_dat_o  = r_dat;

endmodule
